// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: width rules for twiddle products and butterfly sums, the
// half-up rounding constant and a generic saturator shared by radix-2 and radix-4 stages.
package fft_pkg;

  // Working width of the saturator; every datapath value is sign-extended to this first.
  localparam int unsigned SatW = 32;

  // Full-precision complex product width: W x TW plus one bit for the add/sub of two products.
  function automatic int unsigned prod_w(input int unsigned w, input int unsigned tw);
    return w + tw + 32'd1;
  endfunction

  // Butterfly sum width: rounded product (W+2) plus one bit of add/sub growth.
  function automatic int unsigned sum_w(input int unsigned w);
    return w + 32'd3;
  endfunction

  // Half an LSB of the Q1.(TW-1) product once it is shifted right by TW-1.
  function automatic int unsigned rnd_const(input int unsigned tw);
    return 32'd1 << (tw - 32'd2);
  endfunction

  // Clip x to the signed range of a w-bit result; the result stays SatW bits wide.
  function automatic logic signed [SatW-1:0] saturate(input logic signed [SatW-1:0] x,
                                                      input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = $signed((SatW'(1) << (w - 32'd1)) - SatW'(1));
    lo = -hi - 1;
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/cmul_reg.sv
// Registered complex multiplier: p = a * b at full precision, loaded when en_i is high.
// Ports: clk_i/rst_i (async active-high), en_i load enable, a_*_i data operand (W bits),
// b_*_i twiddle (TW bits), p_*_o registered products (W+TW+1 bits).
module cmul_reg
  import fft_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned TW = 8,
  localparam int unsigned ProdW = prod_w(W, TW)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic signed [W-1:0]     a_r_i,
  input  logic signed [W-1:0]     a_i_i,
  input  logic signed [TW-1:0]    b_r_i,
  input  logic signed [TW-1:0]    b_i_i,
  output logic signed [ProdW-1:0] p_r_o,
  output logic signed [ProdW-1:0] p_i_o
);

  logic signed [ProdW-1:0] ar, ai, br, bi;
  logic signed [ProdW-1:0] p_r_d, p_i_d, p_r_q, p_i_q;

  // Extend before multiplying so the products and their sum are exact at ProdW bits.
  always_comb begin
    ar    = {{(ProdW - W){a_r_i[W-1]}}, a_r_i};
    ai    = {{(ProdW - W){a_i_i[W-1]}}, a_i_i};
    br    = {{(ProdW - TW){b_r_i[TW-1]}}, b_r_i};
    bi    = {{(ProdW - TW){b_i_i[TW-1]}}, b_i_i};
    p_r_d = ar * br - ai * bi;
    p_i_d = ar * bi + ai * br;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_r_q <= '0;
      p_i_q <= '0;
    end else if (en_i) begin
      p_r_q <= p_r_d;
      p_i_q <= p_i_d;
    end
  end

  assign p_r_o = p_r_q;
  assign p_i_o = p_i_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: out_1 = in_1 + W*in_2, out_2 = in_1 - W*in_2.
// S1 complex multiply (cmul_reg), S2 half-up round and add/sub, S3 optional 1/2 scale
// and saturation. Valid/ready handshake with a single global advance; all stages stall
// together. Build option: BUTTERFLY_PIPE_SCALE_EN adds a floor divide-by-2 in S3.
// Ports: clk/rst (async active-high), in_valid/in_ready, in_1_*/in_2_* operands,
// tw_* twiddle (Q1.(TW-1)), out_valid/out_ready, out_1_*/out_2_* results,
// ovf sticky saturation flag with synchronous clear clr_ovf.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned TW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_1_r,
  input  logic signed [W-1:0]  in_1_i,
  input  logic signed [W-1:0]  in_2_r,
  input  logic signed [W-1:0]  in_2_i,
  input  logic signed [TW-1:0] tw_r,
  input  logic signed [TW-1:0] tw_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W-1:0]  out_1_r,
  output logic signed [W-1:0]  out_1_i,
  output logic signed [W-1:0]  out_2_r,
  output logic signed [W-1:0]  out_2_i,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  localparam int unsigned ProdW = prod_w(W, TW);
  localparam int unsigned SumW  = sum_w(W);
  localparam logic signed [ProdW-1:0] Rnd = ProdW'(rnd_const(TW));

  logic adv, s1_load, s2_load, s3_load;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic signed [W-1:0]     s1_x1r_q, s1_x1i_q;
  logic signed [ProdW-1:0] s1_pr, s1_pi;
  logic signed [ProdW-1:0] pr_rnd, pi_rnd;
  logic signed [SumW-1:0]  pw_r, pw_i, x1r_ext, x1i_ext;
  logic signed [SumW-1:0]  s2_d [4];
  logic signed [SumW-1:0]  s2_q [4];
  logic signed [SumW-1:0]  sc   [4];
  logic signed [SatW-1:0]  wide [4];
  logic signed [SatW-1:0]  satv [4];
  logic        [3:0]       clip;
  logic signed [W-1:0]     s3_d [4];
  logic signed [W-1:0]     s3_q [4];
  logic ovf_d, ovf_q;

  // Output slot is free or being drained: every stage may shift by one.
  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv;
  assign s1_load  = adv && in_valid;
  assign s2_load  = adv && s1_valid_q;
  assign s3_load  = adv && s2_valid_q;

  // ---------------- S1: products and delayed in_1 ----------------
  cmul_reg #(
    .W (W),
    .TW(TW)
  ) u_cmul (
    .clk_i(clk),
    .rst_i(rst),
    .en_i (s1_load),
    .a_r_i(in_2_r),
    .a_i_i(in_2_i),
    .b_r_i(tw_r),
    .b_i_i(tw_i),
    .p_r_o(s1_pr),
    .p_i_o(s1_pi)
  );

  // ---------------- S2: round half-up, add/sub ----------------
  always_comb begin
    pr_rnd  = (s1_pr + Rnd) >>> (TW - 1);
    pi_rnd  = (s1_pi + Rnd) >>> (TW - 1);
    // The rounded product fits W+2 bits, so the low SumW bits are already sign-extended.
    pw_r    = pr_rnd[SumW-1:0];
    pw_i    = pi_rnd[SumW-1:0];
    x1r_ext = {{(SumW - W){s1_x1r_q[W-1]}}, s1_x1r_q};
    x1i_ext = {{(SumW - W){s1_x1i_q[W-1]}}, s1_x1i_q};
    s2_d[0] = x1r_ext + pw_r;
    s2_d[1] = x1i_ext + pw_i;
    s2_d[2] = x1r_ext - pw_r;
    s2_d[3] = x1i_ext - pw_i;
  end

  // ---------------- S3: optional scale, saturate ----------------
  always_comb begin
    clip = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef BUTTERFLY_PIPE_SCALE_EN
      sc[k] = s2_q[k] >>> 1;
`else
      sc[k] = s2_q[k];
`endif
      wide[k] = {{(SatW - SumW){sc[k][SumW-1]}}, sc[k]};
      satv[k] = saturate(wide[k], W);
      clip[k] = (satv[k] != wide[k]);
      s3_d[k] = satv[k][W-1:0];
    end
  end

  // A new saturation event takes priority over a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (s3_load && (|clip)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_x1r_q   <= '0;
      s1_x1i_q   <= '0;
      ovf_q      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s2_q[k] <= '0;
        s3_q[k] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      if (adv) begin
        s1_valid_q <= in_valid;
        s2_valid_q <= s1_valid_q;
        s3_valid_q <= s2_valid_q;
      end
      if (s1_load) begin
        s1_x1r_q <= in_1_r;
        s1_x1i_q <= in_1_i;
      end
      for (int k = 0; k < 4; k++) begin
        if (s2_load) s2_q[k] <= s2_d[k];
        if (s3_load) s3_q[k] <= s3_d[k];
      end
    end
  end

  assign out_valid = s3_valid_q;
  assign out_1_r   = s3_q[0];
  assign out_1_i   = s3_q[1];
  assign out_2_r   = s3_q[2];
  assign out_2_i   = s3_q[3];
  assign ovf       = ovf_q;

  // Discarded high bits are redundant sign copies.
  logic unused_bits;
  assign unused_bits = ^{pr_rnd[ProdW-1:SumW], pi_rnd[ProdW-1:SumW],
                         satv[0][SatW-1:W], satv[1][SatW-1:W],
                         satv[2][SatW-1:W], satv[3][SatW-1:W]};

endmodule

// File: tb/tb_butterfly_pipe.sv
module tb_butterfly_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [7:0] in_1_r = '0, in_1_i = '0, in_2_r = '0, in_2_i = '0;
  logic signed [7:0] tw_r = '0, tw_i = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [7:0] out_1_r, out_1_i, out_2_r, out_2_i;
  logic ovf;
  logic clr_ovf = 1'b0;

  int checks = 0;
  int passes = 0;

  logic [31:0] outs;
  assign outs = {out_1_r, out_1_i, out_2_r, out_2_i};

  always #5 clk = ~clk;

  butterfly_pipe #(
    .W (8),
    .TW(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_1_r   (in_1_r),
    .in_1_i   (in_1_i),
    .in_2_r   (in_2_r),
    .in_2_i   (in_2_i),
    .tw_r     (tw_r),
    .tw_i     (tw_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_1_r  (out_1_r),
    .out_1_i  (out_1_i),
    .out_2_r  (out_2_r),
    .out_2_i  (out_2_i),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf)
  );

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r = {a[7:0], b[7:0], c[7:0], d[7:0]};
    return r;
  endfunction

  // Bit-accurate reference: returns {clip, out_1_r, out_1_i, out_2_r, out_2_i}.
  function automatic logic [32:0] model(input int x1r, input int x1i, input int x2r,
                                        input int x2i, input int twr, input int twi);
    int pr, pi, wr, wi;
    int a [4];
    logic clp;
    pr = x2r * twr - x2i * twi;
    pi = x2r * twi + x2i * twr;
    wr = (pr + 64) >>> 7;
    wi = (pi + 64) >>> 7;
    a[0] = x1r + wr;
    a[1] = x1i + wi;
    a[2] = x1r - wr;
    a[3] = x1i - wi;
    clp = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef BUTTERFLY_PIPE_SCALE_EN
      a[k] = a[k] >>> 1;
`endif
      if (a[k] > 127) begin
        a[k] = 127;
        clp = 1'b1;
      end else if (a[k] < -128) begin
        a[k] = -128;
        clp = 1'b1;
      end
    end
    return {clp, pk(a[0], a[1], a[2], a[3])};
  endfunction

  task automatic set_in(input int a_r, input int a_i, input int b_r, input int b_i,
                        input int t_r, input int t_i);
    in_1_r = 8'(a_r);
    in_1_i = 8'(a_i);
    in_2_r = 8'(b_r);
    in_2_i = 8'(b_i);
    tw_r   = 8'(t_r);
    tw_i   = 8'(t_i);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, outs} !== 34'd0)
      $display("FAIL reset_state: got valid=%b ovf=%b outs=%h, want 0/0/0", out_valid, ovf, outs);
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", in_ready);
    else passes++;
  endtask

  // Send one pair, confirm no output for two edges, then check result and ovf on the third.
  task automatic one_pair(input string name, input logic [31:0] exp, input logic exp_ovf);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_lat1: out_valid=%b want 0", name, out_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_lat2: out_valid=%b want 0", name, out_valid);
    else passes++;
    @(negedge clk);
    checks++;
    if ({out_valid, outs} !== {1'b1, exp})
      $display("FAIL %s_data: valid=%b outs=%h want 1/%h", name, out_valid, outs, exp);
    else passes++;
    checks++;
    if (ovf !== exp_ovf) $display("FAIL %s_ovf: got %b want %b", name, ovf, exp_ovf);
    else passes++;
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_in(10, 5, 3, -2, -128, 0);
`ifdef BUTTERFLY_PIPE_SCALE_EN
    one_pair("basic", pk(3, 3, 6, 1), 1'b0);
`else
    one_pair("basic", pk(7, 7, 13, 3), 1'b0);
`endif
  endtask

  task automatic test_saturation();
    logic exp_ovf;
    @(negedge clk);
    set_in(127, 0, 100, 0, -128, 0);
`ifdef BUTTERFLY_PIPE_SCALE_EN
    exp_ovf = 1'b0;
    one_pair("sat", pk(13, 0, 113, 0), exp_ovf);
`else
    exp_ovf = 1'b1;
    one_pair("sat", pk(27, 0, 127, 0), exp_ovf);
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (ovf !== exp_ovf) $display("FAIL ovf_sticky: got %b want %b", ovf, exp_ovf);
    else passes++;
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf);
    else passes++;
  endtask

  // Clip lands in S3 on the same edge clr_ovf is high: the set must win.
  task automatic test_ovf_set_wins();
    logic [31:0] exp;
`ifdef BUTTERFLY_PIPE_SCALE_EN
    exp = pk(127, 0, -64, -1);
`else
    exp = pk(127, 1, -128, -1);
`endif
    @(negedge clk);
    set_in(127, 0, -128, 127, -128, -128);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", ovf);
    else passes++;
    checks++;
    if ({out_valid, outs} !== {1'b1, exp})
      $display("FAIL set_wins_data: valid=%b outs=%h want 1/%h", out_valid, outs, exp);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    logic [31:0] held, exp;
    logic stalled_prev;
    int sent, recv, seen;
    pat = 4'b1001;
    sent = 0;
    recv = 0;
    stalled_prev = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      set_in(10 * (sent + 1), sent + 1, sent + 1, 0, -128, 0);
      #1;
      if (stalled_prev) begin
        checks++;
        if ({out_valid, outs} !== {1'b1, held})
          $display("FAIL bp_stable: valid=%b outs=%h want 1/%h", out_valid, outs, held);
        else passes++;
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL bp_in_ready: got %b valid=%b ready=%b", in_ready, out_valid, out_ready);
      else passes++;
      if (out_valid && out_ready) begin
`ifdef BUTTERFLY_PIPE_SCALE_EN
        exp = pk((9 * (recv + 1)) >>> 1, (recv + 1) >>> 1, (11 * (recv + 1)) >>> 1,
                 (recv + 1) >>> 1);
`else
        exp = pk(9 * (recv + 1), recv + 1, 11 * (recv + 1), recv + 1);
`endif
        checks++;
        if (outs !== exp) $display("FAIL bp_order[%0d]: got %h want %h", recv, outs, exp);
        else passes++;
        recv++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = out_valid && !out_ready;
      held = outs;
      if (recv == 8) break;
    end
    checks++;
    if (recv != 8) $display("FAIL bp_count: got %0d results want 8", recv);
    else passes++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL bp_no_dup: got %0d extra results want 0", seen);
    else passes++;
  endtask

  task automatic test_reset_midstream();
    int seen;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(10, 5, 3, -2, -128, 0);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, ovf} !== 2'b11)
      $display("FAIL pre_reset: valid=%b ovf=%b want 1/1", out_valid, ovf);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, ovf, outs} !== 34'd0)
      $display("FAIL midreset_state: valid=%b ovf=%b outs=%h want 0/0/0", out_valid, ovf, outs);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midreset_stale: got %0d results want 0", seen);
    else passes++;
    set_in(-20, 40, 64, 64, 64, -64);
    // p_r = 8192, p_i = 0 -> w = (64, 0)
`ifdef BUTTERFLY_PIPE_SCALE_EN
    one_pair("fresh", pk(22, 20, -42, 20), 1'b0);
`else
    one_pair("fresh", pk(44, 40, -84, 40), 1'b0);
`endif
  endtask

  task automatic test_random();
    localparam int N = 1000;
    logic [31:0] q[$];
    logic [31:0] exp;
    logic [32:0] m;
    logic any_clip;
    logic signed [7:0] r [6];
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    any_clip  = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 3) begin
        exp = q.pop_front();
        checks++;
        if ({out_valid, outs} !== {1'b1, exp})
          $display("FAIL random[%0d]: valid=%b outs=%h want 1/%h", i - 3, out_valid, outs, exp);
        else passes++;
      end
      if (i < N) begin
        for (int k = 0; k < 6; k++) r[k] = 8'($urandom_range(0, 255));
        set_in(int'(r[0]), int'(r[1]), int'(r[2]), int'(r[3]), int'(r[4]), int'(r[5]));
        in_valid = 1'b1;
        m = model(int'(r[0]), int'(r[1]), int'(r[2]), int'(r[3]), int'(r[4]), int'(r[5]));
        q.push_back(m[31:0]);
        any_clip = any_clip | m[32];
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (ovf !== any_clip) $display("FAIL random_ovf: got %b want %b", ovf, any_clip);
    else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_ovf_set_wins();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
